// File: rtl/match_scan_ctrl.sv
// match_scan_ctrl: sequences one library-matching pass. Issues library
// addresses 0..LIB_DEPTH-1 to the sigma engine, keeps the K smallest returned
// sigmas (tagged with their library address) in a sorted table, then streams
// the ranked table out and pulses done.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begin a pass (sampled only while idle)
//   busy, done, err     pass in progress, end-of-pass pulse, sticky stray-result flag
//   lib_rd/lib_ready/lib_addr       address request handshake to the engine
//   sig_valid/sig_data              sigma results, returned in issue order
//   out_valid/out_ready/out_rank/out_sigma/out_addr/out_last  ranked report stream
module match_scan_ctrl #(
  parameter int unsigned LIB_DEPTH = 64,
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned SIG_W     = 18,
  parameter int unsigned K         = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              lib_rd,
  input  logic              lib_ready,
  output logic [ADDR_W-1:0] lib_addr,
  input  logic              sig_valid,
  input  logic [SIG_W-1:0]  sig_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_rank,
  output logic [SIG_W-1:0]  out_sigma,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last
);

  localparam int unsigned CNT_W = $clog2(LIB_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ISSUE, S_DRAIN, S_REPORT, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]   rcv_cnt_q, rcv_cnt_d;
  logic [2:0]         rpt_idx_q, rpt_idx_d;
  logic               err_d;
  logic               sig_ok;

  logic [SIG_W-1:0]   slot_sig_q [K];
  logic [ADDR_W-1:0]  slot_addr_q [K];
  logic [SIG_W-1:0]   slot_sig_d [K];
  logic [ADDR_W-1:0]  slot_addr_d [K];
  logic [SIG_W-1:0]   ins_sig [K];
  logic [ADDR_W-1:0]  ins_addr [K];
  logic [K-1:0]       lt;
  logic [ADDR_W-1:0]  tag;

  // Sorted insert: the table is ascending, so lt[] is monotone (once a slot
  // compares greater, every later slot does too). The first set bit takes the
  // new entry, later set bits take their predecessor, the old tail falls off.
  // Strict compare keeps earlier addresses ahead on ties and never inserts all-ones.
  always_comb begin
    tag = ADDR_W'(rcv_cnt_q);
    for (int i = 0; i < K; i++) begin
      lt[i] = (sig_data < slot_sig_q[i]);
    end
    ins_sig[0]  = lt[0] ? sig_data : slot_sig_q[0];
    ins_addr[0] = lt[0] ? tag      : slot_addr_q[0];
    for (int i = 1; i < K; i++) begin
      if (!lt[i]) begin
        ins_sig[i]  = slot_sig_q[i];
        ins_addr[i] = slot_addr_q[i];
      end else if (!lt[i-1]) begin
        ins_sig[i]  = sig_data;
        ins_addr[i] = tag;
      end else begin
        ins_sig[i]  = slot_sig_q[i-1];
        ins_addr[i] = slot_addr_q[i-1];
      end
    end
  end

  // Next-state, counters, table and sticky error.
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    rcv_cnt_d   = rcv_cnt_q;
    rpt_idx_d   = rpt_idx_q;
    err_d       = err;
    slot_sig_d  = slot_sig_q;
    slot_addr_d = slot_addr_q;
    sig_ok      = ((state_q == S_ISSUE) || (state_q == S_DRAIN)) &&
                  (rcv_cnt_q != CNT_W'(LIB_DEPTH));

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        for (int i = 0; i < K; i++) begin
          slot_sig_d[i]  = '1;
          slot_addr_d[i] = '1;
        end
        issue_cnt_d = '0;
        rcv_cnt_d   = '0;
        rpt_idx_d   = '0;
        err_d       = 1'b0;
        state_d     = S_ISSUE;
      end
      S_ISSUE: begin
        if (lib_rd && lib_ready) begin
          issue_cnt_d = issue_cnt_q + CNT_W'(1);
          if (issue_cnt_q == CNT_W'(LIB_DEPTH - 1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (rcv_cnt_q == CNT_W'(LIB_DEPTH)) state_d = S_REPORT;
      end
      S_REPORT: begin
        if (out_valid && out_ready) begin
          if (rpt_idx_q == 3'(K - 1)) state_d = S_DONE;
          else                        rpt_idx_d = rpt_idx_q + 3'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A result outside the collection window is dropped and flagged; this
    // also overrides the clear in CLEAR so a stray there is not lost.
    if (sig_valid) begin
      if (sig_ok) begin
        slot_sig_d  = ins_sig;
        slot_addr_d = ins_addr;
        rcv_cnt_d   = rcv_cnt_q + CNT_W'(1);
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State, counters, table and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      issue_cnt_q <= '0;
      rcv_cnt_q   <= '0;
      rpt_idx_q   <= '0;
      for (int i = 0; i < K; i++) begin
        slot_sig_q[i]  <= '1;
        slot_addr_q[i] <= '1;
      end
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      lib_rd    <= 1'b0;
      lib_addr  <= '0;
      out_valid <= 1'b0;
      out_rank  <= '0;
      out_sigma <= '0;
      out_addr  <= '0;
      out_last  <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      rcv_cnt_q   <= rcv_cnt_d;
      rpt_idx_q   <= rpt_idx_d;
      slot_sig_q  <= slot_sig_d;
      slot_addr_q <= slot_addr_d;
      busy        <= (state_d != S_IDLE);
      done        <= (state_d == S_DONE);
      err         <= err_d;
      lib_rd      <= (state_d == S_ISSUE);
      lib_addr    <= (state_d == S_ISSUE) ? ADDR_W'(issue_cnt_d) : '0;
      out_valid   <= (state_d == S_REPORT);
      if (state_d == S_REPORT) begin
        out_rank  <= rpt_idx_d;
        out_sigma <= slot_sig_d[rpt_idx_d];
        out_addr  <= slot_addr_d[rpt_idx_d];
        out_last  <= (rpt_idx_d == 3'(K - 1));
      end else begin
        out_rank  <= '0;
        out_sigma <= '0;
        out_addr  <= '0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_match_scan_ctrl.sv
// Bench for match_scan_ctrl: an 8-entry and a 3-entry library instance, a
// bench-side sigma engine (one-cycle latency, optional issue stall) and a
// report sink (optional hold on one rank), checked against hand-ranked tables.
module tb_match_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 8-entry instance
  logic        start8, busy8, done8, err8, lib_rd8, lib_ready8, sig_valid8;
  logic        out_valid8, out_ready8, out_last8;
  logic [5:0]  lib_addr8, out_addr8;
  logic [17:0] sig_data8, out_sigma8;
  logic [2:0]  out_rank8;

  // 3-entry instance
  logic        start3, busy3, done3, err3, lib_rd3, lib_ready3, sig_valid3;
  logic        out_valid3, out_ready3, out_last3;
  logic [5:0]  lib_addr3, out_addr3;
  logic [17:0] sig_data3, out_sigma3;
  logic [2:0]  out_rank3;

  match_scan_ctrl #(.LIB_DEPTH(8), .ADDR_W(6), .SIG_W(18), .K(7)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .busy(busy8), .done(done8), .err(err8),
    .lib_rd(lib_rd8), .lib_ready(lib_ready8), .lib_addr(lib_addr8),
    .sig_valid(sig_valid8), .sig_data(sig_data8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_rank(out_rank8),
    .out_sigma(out_sigma8), .out_addr(out_addr8), .out_last(out_last8));

  match_scan_ctrl #(.LIB_DEPTH(3), .ADDR_W(6), .SIG_W(18), .K(7)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .busy(busy3), .done(done3), .err(err3),
    .lib_rd(lib_rd3), .lib_ready(lib_ready3), .lib_addr(lib_addr3),
    .sig_valid(sig_valid3), .sig_data(sig_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_rank(out_rank3),
    .out_sigma(out_sigma3), .out_addr(out_addr3), .out_last(out_last3));

  typedef struct {
    logic [17:0] sig_in;
    logic [17:0] exp_sig;
    logic [5:0]  exp_addr;
  } vec_t;

  vec_t vec8[8];
  vec_t vec3[7];

  int n_chk = 0;
  int n_pass = 0;
  int cyc_n = 0;

  // engine / sink state for the 8-entry instance
  bit          eng8_en = 1'b1;
  bit          pend8_v = 1'b0;
  int          pend8_a = 0;
  int          ret8 = 0, ret_lim8 = 1000;
  int          iss8[8];
  int          issued8 = 0;
  int          stall_addr = -1, stall_left = 0;
  bit          stalled8 = 1'b0;
  int          hold_rank = -1, hold_left = 0;
  bit          held8 = 1'b0;
  logic [28:0] held_beat;
  logic [27:0] beats8[$];
  int          done_n8 = 0, done_cyc8 = -1, last_cyc8 = -1;

  // engine / sink state for the 3-entry instance
  bit          pend3_v = 1'b0;
  int          pend3_a = 0;
  logic [27:0] beats3[$];
  int          done_n3 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Advance to the next falling edge and run both engines and sinks.
  task automatic cyc();
    @(negedge clk);
    cyc_n++;
    // report sink, 8-entry
    if (held8) begin
      chk("hold_stable", 32'({out_valid8, out_rank8, out_sigma8, out_addr8, out_last8}),
          32'(held_beat));
      held8 = 1'b0;
    end
    if (out_valid8 && (int'(out_rank8) == hold_rank) && hold_left > 0) begin
      out_ready8 = 1'b0;
      hold_left--;
      held8 = 1'b1;
      held_beat = {out_valid8, out_rank8, out_sigma8, out_addr8, out_last8};
    end else begin
      out_ready8 = 1'b1;
    end
    if (out_valid8 && out_ready8) begin
      beats8.push_back({out_rank8, out_sigma8, out_addr8, out_last8});
      if (out_last8) last_cyc8 = cyc_n;
    end
    if (done8) begin
      done_n8++;
      done_cyc8 = cyc_n;
    end
    // sigma engine, 8-entry
    if (eng8_en) begin
      sig_valid8 = pend8_v && (ret8 < ret_lim8);
      if (sig_valid8) begin
        sig_data8 = vec8[pend8_a].sig_in;
        ret8++;
      end
      if (stalled8) begin
        chk("stall_hold", 32'({lib_rd8, lib_addr8}), 32'({1'b1, 6'(stall_addr)}));
        stalled8 = 1'b0;
      end
      if (lib_rd8 && (int'(lib_addr8) == stall_addr) && stall_left > 0) begin
        lib_ready8 = 1'b0;
        stall_left--;
        stalled8 = 1'b1;
      end else begin
        lib_ready8 = 1'b1;
      end
      pend8_v = lib_rd8 && lib_ready8;
      pend8_a = int'(lib_addr8) & 7;
      if (pend8_v) begin
        if (lib_addr8 < 6'd8) iss8[lib_addr8[2:0]]++;
        issued8++;
      end
    end
    // sigma engine and sink, 3-entry (always ready)
    sig_valid3 = pend3_v;
    sig_data3  = vec3[pend3_a].sig_in;
    pend3_v    = lib_rd3;
    pend3_a    = (lib_addr3 < 6'd3) ? int'(lib_addr3) : 0;
    if (out_valid3) beats3.push_back({out_rank3, out_sigma3, out_addr3, out_last3});
    if (done3) done_n3++;
  endtask

  task automatic clear_logs8();
    beats8.delete();
    done_n8 = 0; done_cyc8 = -1; last_cyc8 = -1;
    for (int i = 0; i < 8; i++) iss8[i] = 0;
    issued8 = 0; ret8 = 0; ret_lim8 = 1000;
    pend8_v = 1'b0;
  endtask

  // One full pass on the 8-entry instance with optional stalls and a start poke.
  task automatic run8(input string tn, input int s_addr, input int s_n,
                      input int h_rank, input int h_n, input bit poke);
    int n;
    int bad;
    clear_logs8();
    stall_addr = s_addr; stall_left = s_n;
    hold_rank = h_rank;  hold_left = h_n;
    start8 = 1'b1;
    cyc();
    start8 = 1'b0;
    chk({tn, "_busy_clear"}, 32'(busy8), 32'd1);
    cyc();
    chk({tn, "_err_issue"}, 32'({err8, lib_rd8}), 32'b01);
    if (poke) begin
      cyc();
      start8 = 1'b1;
      cyc();
      start8 = 1'b0;
    end
    n = 0;
    while (done_n8 == 0 && n < 300) begin
      cyc();
      n++;
    end
    chk({tn, "_done_seen"}, 32'(done_n8), 32'd1);
    chk({tn, "_busy_on_done"}, 32'(busy8), 32'd1);
    chk({tn, "_done_latency"}, 32'(done_cyc8 - last_cyc8), 32'd1);
    cyc();
    chk({tn, "_after_done"}, 32'({busy8, done8, out_valid8}), 32'd0);
    chk({tn, "_beats"}, 32'(beats8.size()), 32'd7);
    for (int i = 0; i < 7; i++) begin
      if (i < beats8.size())
        chk($sformatf("%s_rank%0d", tn, i), 32'(beats8[i]),
            32'({3'(i), vec8[i].exp_sig, vec8[i].exp_addr, (i == 6)}));
    end
    bad = 0;
    for (int a = 0; a < 8; a++) if (iss8[a] != 1) bad++;
    chk({tn, "_issue_once"}, 32'(bad), 32'd0);
    chk({tn, "_err_end"}, 32'(err8), 32'd0);
  endtask

  initial begin
    int n;
    // {result in, expected sigma at this rank, expected address at this rank}
    vec8[0] = '{18'd50, 18'd10, 6'd3};
    vec8[1] = '{18'd40, 18'd20, 6'd7};
    vec8[2] = '{18'd60, 18'd30, 6'd6};
    vec8[3] = '{18'd10, 18'd40, 6'd1};
    vec8[4] = '{18'd40, 18'd40, 6'd4};
    vec8[5] = '{18'd70, 18'd50, 6'd0};
    vec8[6] = '{18'd30, 18'd60, 6'd2};
    vec8[7] = '{18'd20, 18'd0,  6'd0};
    vec3[0] = '{18'd5,       18'd5,       6'd0};
    vec3[1] = '{18'd5,       18'd5,       6'd1};
    vec3[2] = '{18'h3FFFF,   18'h3FFFF,   6'h3F};
    for (int i = 3; i < 7; i++) vec3[i] = '{18'd0, 18'h3FFFF, 6'h3F};

    rst_n = 1'b0;
    start8 = 1'b0; lib_ready8 = 1'b1; sig_valid8 = 1'b0; sig_data8 = '0; out_ready8 = 1'b1;
    start3 = 1'b0; lib_ready3 = 1'b1; sig_valid3 = 1'b0; sig_data3 = '0; out_ready3 = 1'b1;
    cyc(); cyc();
    chk("reset_ctl8", 32'({busy8, done8, err8, lib_rd8, lib_addr8, out_valid8, out_rank8, out_last8}), 32'd0);
    chk("reset_data8", 32'({out_sigma8, out_addr8}), 32'd0);
    chk("reset_ctl3", 32'({busy3, done3, err3, lib_rd3, out_valid3, out_last3}), 32'd0);
    rst_n = 1'b1;
    cyc();

    // plain pass, then issue backpressure, then report backpressure
    run8("basic", -1, 0, -1, 0, 1'b0);
    run8("lib_stall", 2, 3, -1, 0, 1'b0);
    run8("out_stall", -1, 0, 3, 2, 1'b0);

    // LIB_DEPTH smaller than K: unfilled slots reported as all-ones
    start3 = 1'b1;
    cyc();
    start3 = 1'b0;
    n = 0;
    while (done_n3 == 0 && n < 100) begin
      cyc();
      n++;
    end
    chk("d3_done", 32'(done_n3), 32'd1);
    chk("d3_beats", 32'(beats3.size()), 32'd7);
    for (int i = 0; i < 7; i++) begin
      if (i < beats3.size())
        chk($sformatf("d3_rank%0d", i), 32'(beats3[i]),
            32'({3'(i), vec3[i].exp_sig, vec3[i].exp_addr, (i == 6)}));
    end
    chk("d3_err", 32'(err3), 32'd0);

    // stray result while idle sets err; next pass clears it and ignores a start poke
    eng8_en = 1'b0;
    sig_valid8 = 1'b1;
    sig_data8 = 18'd1;
    cyc();
    sig_valid8 = 1'b0;
    cyc();
    chk("stray_err", 32'({err8, busy8}), 32'b10);
    eng8_en = 1'b1;
    run8("after_stray", -1, 0, -1, 0, 1'b1);

    // reset while draining: only four results come back, then rst_n drops
    clear_logs8();
    stall_addr = -1; stall_left = 0; hold_rank = -1; hold_left = 0;
    ret_lim8 = 4;
    start8 = 1'b1;
    cyc();
    start8 = 1'b0;
    n = 0;
    while (!(issued8 == 8 && !lib_rd8) && n < 60) begin
      cyc();
      n++;
    end
    cyc(); cyc();
    chk("drain_reached", 32'({busy8, lib_rd8, out_valid8}), 32'b100);
    rst_n = 1'b0;
    #1;
    chk("async_reset", 32'({busy8, lib_rd8, out_valid8, done8, err8}), 32'd0);
    pend8_v = 1'b0;
    sig_valid8 = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    run8("post_reset", -1, 0, -1, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/match_scan_ctrl.md
Name: match_scan_ctrl

Overview:
Sequences one library-matching pass of the gutter-oil detector. On `start` it clears its ranked candidate table and issues library addresses 0..LIB_DEPTH-1 to the sigma (distance) engine with a valid/ready handshake. It collects the returning sigma results and keeps the K smallest, each tagged with its library address. It then streams the ranked list to the decision logic and pulses `done`.

Parameters:
LIB_DEPTH, 64, number of library entries scanned per pass (>=1)
ADDR_W, 6, library address width (2^ADDR_W >= LIB_DEPTH)
SIG_W, 18, sigma result width (unsigned)
K, 7, number of ranked candidates kept (1..8)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin pass; sampled only in IDLE
busy  out  1  high from accepted start until done pulse (inclusive)
done  out  1  one-cycle pulse after last report beat accepted
err  out  1  sticky: unexpected sig_valid; cleared on accepted start
lib_rd  out  1  address request valid
lib_ready  in  1  engine accepts lib_addr when lib_rd&lib_ready
lib_addr  out  ADDR_W  library address being requested
sig_valid  in  1  sigma result valid (results return in issue order)
sig_data  in  SIG_W  sigma result
out_valid  out  1  report beat valid
out_ready  in  1  report beat accepted when out_valid&out_ready
out_rank  out  3  rank 0 = smallest sigma
out_sigma  out  SIG_W  candidate sigma
out_addr  out  ADDR_W  candidate library address
out_last  out  1  high on rank K-1 beat

Behaviour:
- Reset values: all outputs 0. Table slots hold sigma all-ones and addr all-ones. State IDLE, counters 0.
- FSM:
  - IDLE --start--> CLEAR.
  - CLEAR (1 cycle): every slot set to sigma all-ones and addr all-ones; issue_cnt=0, rcv_cnt=0; err cleared. Next state ISSUE.
  - ISSUE: lib_rd=1, lib_addr=issue_cnt. issue_cnt increments on each handshake. After the handshake at issue_cnt=LIB_DEPTH-1, lib_rd drops the next cycle and the FSM goes to DRAIN. lib_addr and lib_rd hold stable while lib_ready=0.
  - DRAIN: wait until rcv_cnt==LIB_DEPTH, then go to REPORT.
  - REPORT: beats for ranks 0..K-1 in order. Each beat holds stable until accepted. After the out_last beat is accepted: done=1 for one cycle, then IDLE.
- busy is high in all states except IDLE. It is still high on the done cycle and low the cycle after.
- Result capture: sig_valid is accepted in ISSUE or DRAIN while rcv_cnt<LIB_DEPTH. The tag is the current rcv_cnt value, and rcv_cnt then increments. Results may arrive in the same cycle as an issue handshake.
- Insert rule (one result per cycle, no backpressure on results):
  - Position p is the first slot with sig_data < slot[p] (strict).
  - Slots p..K-2 shift down one place; slot K-1 is discarded.
  - slot[p] is written with {sig_data, tag}.
  - If no slot qualifies, the table is unchanged.
  - Ties keep the earlier address at the better rank.
  - sig_data equal to all-ones is never inserted.
- Table updates complete on the accepting cycle. A result arriving in the cycle that DRAIN reaches rcv_cnt==LIB_DEPTH is reflected in REPORT.
- Unfilled slots (only possible when LIB_DEPTH<K) are reported as sigma all-ones, addr all-ones.
- err: set on sig_valid in IDLE, CLEAR or REPORT, or when rcv_cnt==LIB_DEPTH. The offending result is dropped. err holds until the next accepted start.
- start while busy is ignored and does not restart the pass.
- rst_n asserted mid-pass returns everything to reset values immediately. No partial report is produced.

Test Plan:
- LIB_DEPTH=8, K=7, lib_ready=1, results 50,40,60,10,40,70,30,20 (addr 0..7) -> report (10,3)(20,7)(30,6)(40,1)(40,4)(50,0)(60,2); 70 dropped; out_last on rank 6; done one cycle after that acceptance; err=0.
- Issue backpressure: lib_ready low 3 cycles at addr 2 -> lib_addr stays 2 and lib_rd stays 1; addresses 0..7 each issued exactly once; report identical to the first test.
- Report backpressure: out_ready low 2 cycles on rank 3 -> rank 3 beat held stable, no beat skipped; done only after rank 6 is accepted.
- LIB_DEPTH=3, results 5,5,0x3FFFF -> ranks (5,0)(5,1) then five beats of (0x3FFFF, 0x3F).
- Stray sig_valid in IDLE -> err=1, table unchanged; next start clears err in CLEAR; start pulsed during ISSUE is ignored.
- rst_n low during DRAIN -> busy=0, lib_rd=0, out_valid=0 immediately; a fresh pass afterwards produces a correct report with no stale entries.
